// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 fetch front-end.
// Owns the PC and issues word-aligned requests to a variable-latency
// instruction memory. Returned words go into an in-order prefetch queue,
// and the queue head is offered to decode.
// A redirect flushes the queue and discards responses that are still in flight.
//
// Handshake rule for every valid/ready pair in this block: a transfer happens
// in a cycle exactly when valid && ready at the rising edge. Once valid is
// raised, the payload holds steady until that transfer happens or a
// redirect/reset withdraws it. The memory response port has no ready and is
// taken whenever it is valid.
//
// Optional build macro: FETCH_PERF_EN adds the fetch_stall_cnt output.
// That output counts cycles in which decode was ready but no instruction
// was available.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  // architectural state
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  // prefetch queue storage
  logic [ILEN-1:0] q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];

  // per-cycle decisions
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] redirect_aligned;

  // Issue gating, response classification and decode-side outputs.
  always_comb begin
    occupancy        = {1'b0, count} + {1'b0, outstanding};
    redirect_aligned = redirect_pc & ALIGN_MASK;

    imem_req_valid = !rst && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
    imem_req_addr  = next_pc & ALIGN_MASK;
    req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a leftover from before a reset.
    rsp_take = imem_rsp_valid && (outstanding != '0);
    rsp_drop = rsp_take && (redirect_valid || (drop_cnt != '0));
    push     = rsp_take && !rsp_drop;

    instr_valid = (count != '0) && !redirect_valid;
    pop         = instr_valid && instr_ready;
    instr       = '0;
    instr_pc    = '0;
    if (count != '0) begin
      instr    = q_data[rd_ptr];
      instr_pc = q_pc[rd_ptr];
    end
  end

  // PC, pointer and counter state; a redirect overrides normal bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_pc     <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      next_pc     <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      // Everything still in flight after this cycle belongs to the old path.
      outstanding <= outstanding - CW'(rsp_take);
      drop_cnt    <= outstanding - CW'(rsp_take);
    end else begin
      if (req_fire) begin
        next_pc <= next_pc + PC_STEP;
      end
      if (push) begin
        rsp_pc <= rsp_pc + PC_STEP;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (rsp_take && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
    end
  end

  // Queue write port; contents need no reset because count guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_rsp_data;
      q_pc[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating count of cycles where decode waited on fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_stall_cnt <= '0;
    end else if (instr_ready && !instr_valid && (fetch_stall_cnt != '1)) begin
      fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised fetch front-end for the RV32 core; replaces the fixed single-cycle PC path.
- Owns the PC, issues requests to a variable-latency instruction memory through a valid/ready port, and buffers returned words in an in-order prefetch queue.
- Presents instructions to the decode/controller stage over a valid/ready handshake and supports a pipeline redirect (branch/jump) with flush of stale fetches.

Parameters:
- XLEN, 32, PC and address width.
- ILEN, 32, instruction word width.
- DEPTH, 4, prefetch queue entries and maximum in-flight plus buffered fetches; power of 2, minimum 2.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  fetch address, word aligned.
- imem_rsp_valid  input  1  response valid; in order, no backpressure.
- imem_rsp_data  input  ILEN  returned instruction.
- redirect_valid  input  1  redirect the PC and flush.
- redirect_pc  input  XLEN  target PC.
- instr_valid  output  1  instruction available to decode.
- instr_ready  input  1  decode consumes the instruction.
- instr  output  ILEN  instruction at queue head.
- instr_pc  output  XLEN  PC of that instruction.

Behaviour:
Reset and clocking:
- Reset is asynchronous, active-high; clk is the single clock.
- Reset values: next_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
- Outputs under reset: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
- Counters are clog2(DEPTH)+1 bits wide.
- PC arithmetic wraps modulo 2^XLEN.

Request issue:
- imem_req_valid = !rst && !redirect_valid && (count+outstanding < DEPTH).
- imem_req_addr = next_pc with the low 2 bits forced to 0.
- On an accepted request (valid && ready): next_pc += 4, outstanding += 1.
- A response decrements outstanding. Accept and response in the same cycle leave outstanding unchanged.

Response handling:
- If drop_cnt>0, the response is discarded and drop_cnt -= 1.
- Otherwise {rsp_pc, imem_rsp_data} is pushed into the queue and rsp_pc += 4.
- The queue cannot overflow because issue is gated on count+outstanding. Push and pop in the same cycle are legal at any occupancy.

Decode handshake:
- instr_valid = (count != 0) && !redirect_valid.
- instr and instr_pc come from the queue head and are stable while instr_valid && !instr_ready.
- Pop occurs on instr_valid && instr_ready.

Redirect (cycle N):
- Queue is flushed (count=0) and no request is issued in cycle N.
- next_pc and rsp_pc <= redirect_pc with bits[1:0] cleared.
- drop_cnt <= outstanding, minus 1 if a response arrives in N; that response is itself discarded.
- If drop_cnt was already nonzero, the same rule applies to the total still in flight.
- The earliest request at the new target is issued in cycle N+1.

Latency:
- A response in cycle M gives instr_valid in cycle M+1, because the queue is registered.
- With zero-wait memory (ready=1, response in the cycle after the request), steady state delivers 1 instruction per cycle.

Boundary conditions:
- Redirect during reset is ignored.
- Back-to-back redirects: the last one wins; drop counting stays exact.
- Reset mid-transfer: all state clears; responses arriving after reset deassertion with outstanding=0 are ignored and are not pushed.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output port fetch_stall_cnt (32 bits). It counts cycles where instr_ready=1 and instr_valid=0, saturates at 2^32-1, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Zero-wait memory returning data = address: after reset, instr_pc sequence 0x0,0x4,0x8…; instr_valid continuous from the 3rd cycle; 1 instruction per cycle.
- Hold instr_ready=0 with DEPTH=4: at most 4 requests are issued, then imem_req_valid=0. Release instr_ready: the 4 entries drain in order and fetch resumes at 0x10.
- Memory with 3-cycle latency, 2 requests in flight, redirect_pc=0x100: both stale responses are dropped; the first instr_pc is 0x100 with data from 0x100.
- redirect_pc=0x103: imem_req_addr=0x100; instr_pc=0x100.
- Assert rst mid-stream with 2 requests outstanding: outputs clear immediately. After release, the first request is to RESET_PC and late stale responses are not delivered.
- FETCH_PERF_EN defined, instr_ready=1, memory stalled with ready=0 for 10 cycles after the queue drains: fetch_stall_cnt increases by 10.
